// File: rtl/rv_mc_datapath.sv
// Multi-cycle RV32I-class datapath: a FETCH/DECODE/EXEC/MEM/WB phase FSM driving req/ready instruction and data buses.
// Defining DP_PERF_CNT_EN adds the cycle_cnt/instret_cnt performance counter outputs.
module rv_mc_datapath #(
   parameter int              XLEN     = 32,
   parameter int              NUM_REGS = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   output logic            instr_req,
   output logic [XLEN-1:0] instr_addr,
   input  logic [31:0]     instr_rdata,
   input  logic            instr_ready,
   output logic [31:0]     instr_code,
   input  logic            reg_we,
   input  logic            alu_src_sel,
   input  logic            branch,
   input  logic            jal,
   input  logic            jalr,
   input  logic            mem_rd,
   input  logic            mem_wr,
   input  logic [3:0]      alu_ctrl,
   input  logic [2:0]      rfwd_sel,
   output logic            bus_req,
   output logic            bus_we,
   output logic [XLEN-1:0] bus_addr,
   output logic [XLEN-1:0] bus_wdata,
   input  logic [XLEN-1:0] bus_rdata,
   input  logic            bus_ready,
   output logic [2:0]      phase,
   output logic            retire
`ifdef DP_PERF_CNT_EN
   ,
   output logic [63:0]     cycle_cnt,
   output logic [63:0]     instret_cnt
`endif
);
   localparam int RW = $clog2(NUM_REGS);
   localparam int SW = $clog2(XLEN);

   typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4} phase_t;
   phase_t state, nxt;

   logic [XLEN-1:0] pc, a, b, imm, alu_out, mdr;
   logic [31:0]     ir, imm32;
   logic [XLEN-1:0] rf [NUM_REGS];
   logic [XLEN-1:0] rf_rs1, rf_rs2, imm_ext, opb, alu_res, wb_data, pc_plus4, pc_wb;
   logic [SW-1:0]   shamt;
   logic            btaken;
   logic [4:0]      rs1, rs2, rd;

   assign rs1        = ir[19:15];
   assign rs2        = ir[24:20];
   assign rd         = ir[11:7];
   assign instr_addr = pc;
   assign instr_code = ir;
   assign bus_addr   = alu_out;
   assign bus_wdata  = b;
   assign phase      = state;
   assign pc_plus4   = pc + XLEN'(4);
   assign rf_rs1     = (rs1 == 5'd0) ? '0 : rf[rs1[RW-1:0]];
   assign rf_rs2     = (rs2 == 5'd0) ? '0 : rf[rs2[RW-1:0]];

   always_comb begin
      unique case (ir[6:0])
         7'b0010011, 7'b0000011, 7'b1100111: imm32 = {{20{ir[31]}}, ir[31:20]};
         7'b0100011: imm32 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
         7'b1100011: imm32 = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
         7'b0110111, 7'b0010111: imm32 = {ir[31:12], 12'h000};
         7'b1101111: imm32 = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
         default: imm32 = 32'h0;
      endcase
      imm_ext = XLEN'($signed(imm32));
   end

   always_comb begin
      opb     = alu_src_sel ? imm : b;
      shamt   = opb[SW-1:0];
      btaken  = 1'b0;
      alu_res = '0;
      case (alu_ctrl)
         4'd0:  alu_res = a + opb;
         4'd1:  alu_res = a - opb;
         4'd2:  alu_res = a & opb;
         4'd3:  alu_res = a | opb;
         4'd4:  alu_res = a ^ opb;
         4'd5:  alu_res = a << shamt;
         4'd6:  alu_res = a >> shamt;
         4'd7:  alu_res = $signed(a) >>> shamt;
         4'd8:  alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(opb)};
         4'd9:  alu_res = {{(XLEN-1){1'b0}}, a < opb};
         4'd10: btaken  = (a == opb);
         4'd11: btaken  = (a != opb);
         4'd12: btaken  = $signed(a) < $signed(opb);
         4'd13: btaken  = $signed(a) >= $signed(opb);
         4'd14: btaken  = a < opb;
         4'd15: btaken  = a >= opb;
         default: alu_res = '0;
      endcase
      // Compare ops latch their outcome into ALUOut.
      if (alu_ctrl[3] && (alu_ctrl[2] || alu_ctrl[1]))
         alu_res = {{(XLEN-1){1'b0}}, btaken};
   end

   always_comb begin
      case (rfwd_sel)
         3'd0:    wb_data = alu_out;
         3'd1:    wb_data = mdr;
         3'd2:    wb_data = imm;
         3'd3:    wb_data = pc + imm;
         3'd4:    wb_data = pc_plus4;
         default: wb_data = '0;
      endcase
      if (jal)       pc_wb = pc + imm;
      else if (jalr) pc_wb = (a + imm) & ~XLEN'(1);
      else           pc_wb = pc_plus4;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= FETCH;
      else       state <= nxt;
   end

   always_comb begin
      nxt       = state;
      instr_req = 1'b0;
      bus_req   = 1'b0;
      bus_we    = 1'b0;
      retire    = 1'b0;
      case (state)
         FETCH: begin
            instr_req = 1'b1;
            if (instr_ready) nxt = DECODE;
         end
         DECODE: nxt = EXEC;
         EXEC: begin
            if (branch) begin
               retire = 1'b1;
               nxt    = FETCH;
            end else if (mem_rd || mem_wr) nxt = MEM;
            else nxt = WB;
         end
         MEM: begin
            bus_req = 1'b1;
            bus_we  = mem_wr;
            if (bus_ready) begin
               retire = mem_wr;
               nxt    = mem_wr ? FETCH : WB;
            end
         end
         WB: begin
            retire = 1'b1;
            nxt    = FETCH;
         end
         default: nxt = FETCH;
      endcase
      if (reset) begin
         instr_req = 1'b0;
         bus_req   = 1'b0;
         bus_we    = 1'b0;
         retire    = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc      <= RESET_PC;
         ir      <= 32'h0000_0013;
         a       <= '0;
         b       <= '0;
         imm     <= '0;
         alu_out <= '0;
         mdr     <= '0;
      end else begin
         case (state)
            FETCH: if (instr_ready) ir <= instr_rdata;
            DECODE: begin
               a   <= rf_rs1;
               b   <= rf_rs2;
               imm <= imm_ext;
            end
            EXEC: begin
               alu_out <= alu_res;
               if (branch) pc <= btaken ? pc + imm : pc_plus4;
            end
            MEM: if (bus_ready) begin
               if (mem_wr) pc  <= pc_plus4;
               else        mdr <= bus_rdata;
            end
            WB: pc <= pc_wb;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && state == WB && reg_we && rd != 5'd0)
         rf[rd[RW-1:0]] <= wb_data;
   end

`ifdef DP_PERF_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cycle_cnt   <= '0;
         instret_cnt <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 64'd1;
         if (retire) instret_cnt <= instret_cnt + 64'd1;
      end
   end
`endif
endmodule
